// File: rtl/pic10_pkg.sv
// Shared constants and types for the PIC10 datapath.
package pic10_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/pic10_reg8.sv
// Data register with synchronous active-high reset and load enable.
module pic10_reg8
  import pic10_pkg::*;
#(
  parameter int unsigned Width = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_d;
  logic [Width-1:0] q_q;

  // Reset wins over load so a write in a reset cycle is discarded.
  always_comb begin
    q_d = q_q;
    if (reset) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pic10_ram_registers.sv
// PIC10 general-purpose register file: one-hot write decode, per-register storage,
// combinational read mux with no write-through bypass.
module pic10_ram_registers #(
  parameter int unsigned DATA_W   = pic10_pkg::DATA_W,
  parameter int unsigned ADDR_W   = pic10_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = pic10_pkg::NUM_REGS
) (
  output logic [DATA_W-1:0] ram_data_bus,
  input  logic              load_ram_reg,
  input  logic [ADDR_W-1:0] reg_addr_bus,
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_bus
);

  logic [NUM_REGS-1:0] write_en;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  always_comb begin
    write_en = '0;
    if (load_ram_reg) begin
      write_en[reg_addr_bus] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    pic10_reg8 #(
      .Width(DATA_W)
    ) u_reg (
      .clk  (clk),
      .reset(reset),
      .load (write_en[i]),
      .d    (alu_bus),
      .q    (regs[i])
    );
  end

  // Read shows stored contents only; a pending write appears after the clock edge.
  always_comb begin
    ram_data_bus = regs[reg_addr_bus];
  end

endmodule

// File: tb/tb_pic10_ram_registers.sv
// Directed self-checking bench for pic10_ram_registers.
module tb_pic10_ram_registers;

  logic       clk;
  logic       reset;
  logic       load_ram_reg;
  logic [4:0] reg_addr_bus;
  logic [7:0] alu_bus;
  logic [7:0] ram_data_bus;

  int checks;
  int errors;

  pic10_ram_registers dut (
    .ram_data_bus(ram_data_bus),
    .load_ram_reg(load_ram_reg),
    .reg_addr_bus(reg_addr_bus),
    .clk         (clk),
    .reset       (reset),
    .alu_bus     (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       load;
    logic [4:0] addr;
    logic [7:0] alu;
    logic [7:0] exp_pre;
    logic [7:0] exp_post;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clocked cycle with inputs applied after the falling edge.
  task automatic cycle(input logic r, input logic l, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    reset        = r;
    load_ram_reg = l;
    reg_addr_bus = a;
    alu_bus      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input string name, input logic [4:0] a, input logic [7:0] exp);
    @(negedge clk);
    reset        = 1'b0;
    load_ram_reg = 1'b0;
    reg_addr_bus = a;
    #1;
    check($sformatf("%s addr %0d", name, a), ram_data_bus, exp);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    load_ram_reg = 1'b0;
    reg_addr_bus = '0;
    alu_bus      = '0;

    vecs[0]  = '{"rdw addr5",        1'b0, 1'b1, 5'd5,  8'h99, 8'h45, 8'h99};
    vecs[1]  = '{"neighbour addr4",  1'b0, 1'b0, 5'd4,  8'hFF, 8'h44, 8'h44};
    vecs[2]  = '{"neighbour addr6",  1'b0, 1'b0, 5'd6,  8'hFF, 8'h46, 8'h46};
    vecs[3]  = '{"reset priority",   1'b1, 1'b1, 5'd10, 8'h77, 8'h4A, 8'h00};
    vecs[4]  = '{"cleared addr5",    1'b0, 1'b0, 5'd5,  8'h00, 8'h00, 8'h00};
    vecs[5]  = '{"write addr31",     1'b0, 1'b1, 5'd31, 8'hC3, 8'h00, 8'hC3};
    vecs[6]  = '{"write addr0",      1'b0, 1'b1, 5'd0,  8'h3C, 8'h00, 8'h3C};
    vecs[7]  = '{"retain addr31",    1'b0, 1'b0, 5'd31, 8'h00, 8'hC3, 8'hC3};
    vecs[8]  = '{"retain addr0",     1'b0, 1'b0, 5'd0,  8'hFF, 8'h3C, 8'h3C};
    vecs[9]  = '{"write addr1",      1'b0, 1'b1, 5'd1,  8'h5A, 8'h00, 8'h5A};
    vecs[10] = '{"addr0 after addr1", 1'b0, 1'b0, 5'd0, 8'h00, 8'h3C, 8'h3C};

    cycle(1'b1, 1'b0, 5'd0, 8'h00);
    cycle(1'b1, 1'b0, 5'd0, 8'h00);
    for (int n = 0; n < 32; n++) read_at("post-reset zero", n[4:0], 8'h00);

    // Reset clears a previously written register
    cycle(1'b0, 1'b1, 5'd3, 8'hA5);
    read_at("A5 written", 5'd3, 8'hA5);
    cycle(1'b1, 1'b0, 5'd3, 8'h00);
    for (int n = 0; n < 32; n++) read_at("reset sweep", n[4:0], 8'h00);

    for (int n = 0; n < 32; n++) cycle(1'b0, 1'b1, n[4:0], 8'h40 + n[7:0]);
    for (int n = 0; n < 32; n++) read_at("fill", n[4:0], 8'h40 + n[7:0]);

    for (int n = 0; n < 32; n++) cycle(1'b0, 1'b0, n[4:0], 8'hFF);
    for (int n = 0; n < 32; n++) read_at("write disable", n[4:0], 8'h40 + n[7:0]);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset        = vecs[i].rst;
      load_ram_reg = vecs[i].load;
      reg_addr_bus = vecs[i].addr;
      alu_bus      = vecs[i].alu;
      #1;
      check({vecs[i].name, " pre-edge"}, ram_data_bus, vecs[i].exp_pre);
      @(posedge clk);
      #1;
      check({vecs[i].name, " post-edge"}, ram_data_bus, vecs[i].exp_post);
    end

    // Final spot checks: reset in the table cleared everything not rewritten since
    read_at("final addr10", 5'd10, 8'h00);
    read_at("final addr31", 5'd31, 8'hC3);
    read_at("final addr1",  5'd1,  8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
